// File: rtl/letc_core_pkg.sv
// Shared LETC core types plus the write-back arbiter's request record,
// grant encoding and parameter defaults.
package letc_core_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_idx_t rd_idx;
        word_t    wdata;
    } wb_req_s;

    localparam int WB_LR_FIFO_DEPTH = 2;
    localparam int WB_STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {
        WB_GNT_NONE = 2'd0,
        WB_GNT_W    = 2'd1,
        WB_GNT_H    = 2'd2
    } wb_gnt_e;

    function automatic logic [31:0] reg_onehot(input reg_idx_t idx);
        reg_onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/letc_core_wb_lr_fifo.sv
// Small FIFO buffering long-latency results until they win the register-file
// write port; exposes per-entry valid/index so the top can build pending bits.
module letc_core_wb_lr_fifo
    import letc_core_pkg::*;
#(
    parameter int DEPTH = WB_LR_FIFO_DEPTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [4:0]           i_push_idx,
    input  logic [31:0]          i_push_wdata,
    input  logic                 i_pop,
    output logic [4:0]           o_head_idx,
    output logic [31:0]          o_head_wdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [DEPTH-1:0]     o_valid,
    output logic [DEPTH*5-1:0]   o_idx
);

    localparam int AW = $clog2(DEPTH);

    wb_req_s          r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= (AW+1)'(0);
            r_rd_ptr <= (AW+1)'(0);
            r_valid  <= {DEPTH{1'b0}};
        end else begin
            // Clear before set: a slot is never popped and pushed in one cycle.
            if (i_pop) begin
                r_rd_ptr                   <= r_rd_ptr + (AW+1)'(1);
                r_valid[r_rd_ptr[AW-1:0]]  <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr                   <= r_wr_ptr + (AW+1)'(1);
                r_valid[r_wr_ptr[AW-1:0]]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= '{rd_idx: i_push_idx, wdata: i_push_wdata};
        end
    end

    always_comb begin
        o_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        o_empty      = (r_wr_ptr == r_rd_ptr);
        o_head_idx   = r_mem[r_rd_ptr[AW-1:0]].rd_idx;
        o_head_wdata = r_mem[r_rd_ptr[AW-1:0]].wdata;
        o_valid      = r_valid;
        o_idx        = {(DEPTH*5){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            o_idx[i*5 +: 5] = r_mem[i].rd_idx;
        end
    end

endmodule

// File: rtl/letc_core_wb_arbiter.sv
// Shares the single integer register-file write port between the W stage and
// buffered long-latency results, keeping WAW order and LR forward progress.
module letc_core_wb_arbiter
    import letc_core_pkg::*;
#(
    parameter int LR_FIFO_DEPTH = WB_LR_FIFO_DEPTH,
    parameter int STARVE_LIMIT  = WB_STARVE_LIMIT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_w_valid,
    input  logic [4:0]  i_w_rd_idx,
    input  logic [31:0] i_w_rd_wdata,
    output logic        o_w_stall,
    input  logic        i_lr_valid,
    output logic        o_lr_ready,
    input  logic [4:0]  i_lr_rd_idx,
    input  logic [31:0] i_lr_wdata,
    output logic [4:0]  o_rd_idx,
    output logic [31:0] o_rd_wdata,
    output logic        o_rd_wen,
    output logic [31:0] o_lr_pending
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0]              r_starve_cnt;
    logic                       w_full;
    logic                       w_empty;
    logic [4:0]                 w_head_idx;
    logic [31:0]                w_head_wdata;
    logic [LR_FIFO_DEPTH-1:0]   w_valid;
    logic [LR_FIFO_DEPTH*5-1:0] w_idx;
    logic [31:0]                w_pending;
    logic                       w_w_cand;
    logic                       w_h_cand;
    logic                       w_push;
    logic                       w_pop;
    wb_gnt_e                    w_gnt;

    letc_core_wb_lr_fifo #(
        .DEPTH (LR_FIFO_DEPTH)
    ) u_lr_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_idx   (i_lr_rd_idx),
        .i_push_wdata (i_lr_wdata),
        .i_pop        (w_pop),
        .o_head_idx   (w_head_idx),
        .o_head_wdata (w_head_wdata),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_valid      (w_valid),
        .o_idx        (w_idx)
    );

    // x0 writes complete their handshake but never reach the FIFO or the port.
    always_comb begin
        o_lr_ready = !w_full && !i_rst;
        w_push     = i_lr_valid && o_lr_ready && (i_lr_rd_idx != 5'd0);
        w_w_cand   = i_w_valid && (i_w_rd_idx != 5'd0);
        w_h_cand   = !w_empty;
        w_pending  = 32'd0;
        for (int i = 0; i < LR_FIFO_DEPTH; i++) begin
            if (w_valid[i]) begin
                w_pending = w_pending | reg_onehot(w_idx[i*5 +: 5]);
            end else begin
                w_pending = w_pending;
            end
        end
    end

    always_comb begin
        w_gnt = WB_GNT_NONE;
        if (i_rst) begin
            w_gnt = WB_GNT_NONE;
        end else if (w_w_cand && w_pending[i_w_rd_idx]) begin
            w_gnt = WB_GNT_H;
        end else if (w_w_cand && w_h_cand && (r_starve_cnt == STARVE_MAX)) begin
            w_gnt = WB_GNT_H;
        end else if (w_w_cand) begin
            w_gnt = WB_GNT_W;
        end else if (w_h_cand) begin
            w_gnt = WB_GNT_H;
        end else begin
            w_gnt = WB_GNT_NONE;
        end
    end

    always_comb begin
        o_rd_idx     = 5'd0;
        o_rd_wdata   = 32'd0;
        o_rd_wen     = 1'b0;
        w_pop        = 1'b0;
        case (w_gnt)
            WB_GNT_W: begin
                o_rd_idx   = i_w_rd_idx;
                o_rd_wdata = i_w_rd_wdata;
                o_rd_wen   = 1'b1;
            end
            WB_GNT_H: begin
                o_rd_idx   = w_head_idx;
                o_rd_wdata = w_head_wdata;
                o_rd_wen   = 1'b1;
                w_pop      = 1'b1;
            end
            default: begin
                o_rd_wen   = 1'b0;
            end
        endcase
        o_w_stall    = !i_rst && w_w_cand && (w_gnt != WB_GNT_W);
        if (i_rst) begin
            o_lr_pending = 32'd0;
        end else begin
            o_lr_pending = w_pending;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= SW'(0);
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= SW'(0);
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: tb/tb_letc_core_wb_arbiter.sv
// Directed and random stimulus for the write-back arbiter, checked each cycle
// against a queue-based reference of the arbitration rules.
module tb_letc_core_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_valid;
    logic [4:0]  w_idx;
    logic [31:0] w_data;
    logic        w_stall;
    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_idx;
    logic [31:0] lr_data;
    logic [4:0]  rd_idx;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic [31:0] lr_pending;

    letc_core_wb_arbiter #(.LR_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_w_valid    (w_valid),
        .i_w_rd_idx   (w_idx),
        .i_w_rd_wdata (w_data),
        .o_w_stall    (w_stall),
        .i_lr_valid   (lr_valid),
        .o_lr_ready   (lr_ready),
        .i_lr_rd_idx  (lr_idx),
        .i_lr_wdata   (lr_data),
        .o_rd_idx     (rd_idx),
        .o_rd_wdata   (rd_wdata),
        .o_rd_wen     (rd_wen),
        .o_lr_pending (lr_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic [31:0] mrf [32];
    logic [31:0] drf [32];
    logic [4:0]  lr_log[$];
    logic        m_stall;
    int          n_vec;
    int          n_err;

    logic        obs_ready, obs_wen, obs_stall;
    logic [4:0]  obs_idx;
    logic [31:0] obs_data, obs_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare at negedge against the reference, advance.
    task automatic step(input logic r, input logic wv, input logic [4:0] wi, input logic [31:0] wd,
                        input logic lv, input logic [4:0] li, input logic [31:0] ld);
        logic        e_ready, e_wen, e_stall, wc, hc, was_empty;
        logic [4:0]  e_idx;
        logic [31:0] e_data, e_pend;
        int          g;
        ent_t        h;
        rst = r; w_valid = wv; w_idx = wi; w_data = wd;
        lr_valid = lv; lr_idx = li; lr_data = ld;
        @(negedge clk);
        obs_ready = lr_ready; obs_wen = rd_wen; obs_stall = w_stall;
        obs_idx = rd_idx; obs_data = rd_wdata; obs_pend = lr_pending;
        e_pend = 32'd0;
        foreach (q[k]) e_pend[q[k].idx] = 1'b1;
        wc = wv && (wi != 5'd0);
        hc = (q.size() > 0);
        g = 0;
        if (r) g = 0;
        else if (wc && e_pend[wi]) g = 2;
        else if (wc && hc && starve == LIMIT) g = 2;
        else if (wc) g = 1;
        else if (hc) g = 2;
        e_ready = !r && (q.size() < DEPTH);
        e_wen   = (g != 0);
        e_idx   = (g == 1) ? wi : (g == 2) ? q[0].idx : 5'd0;
        e_data  = (g == 1) ? wd : (g == 2) ? q[0].d : 32'd0;
        e_stall = !r && wc && (g != 1);
        if (r) e_pend = 32'd0;
        chk("lr_ready", {31'd0, obs_ready}, {31'd0, e_ready});
        chk("rd_wen",   {31'd0, obs_wen},   {31'd0, e_wen});
        chk("rd_idx",   {27'd0, obs_idx},   {27'd0, e_idx});
        chk("rd_wdata", obs_data, e_data);
        chk("w_stall",  {31'd0, obs_stall}, {31'd0, e_stall});
        chk("lr_pending", obs_pend, e_pend);
        if (obs_wen) begin
            drf[obs_idx] = obs_data;
            if (g == 2) lr_log.push_back(obs_idx);
        end
        m_stall = e_stall;
        if (r) begin
            q.delete();
            starve = 0;
        end else begin
            was_empty = (q.size() == 0);
            if (g == 2) begin
                h = q.pop_front();
                mrf[h.idx] = h.d;
            end else if (g == 1) begin
                mrf[wi] = wd;
            end
            if (lv && e_ready && li != 5'd0) q.push_back('{idx: li, d: ld});
            if (g == 2 || was_empty) starve = 0;
            else if (starve < LIMIT) starve++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        wv_r;
        logic [4:0]  wi_r;
        logic [31:0] wd_r;
        n_vec = 0; n_err = 0; starve = 0; m_stall = 1'b0;
        for (int i = 0; i < 32; i++) begin mrf[i] = 32'd0; drf[i] = 32'd0; end
        @(posedge clk); #1;

        // Reset then idle
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        chk("rst_ready", {31'd0, obs_ready}, 32'd0);
        chk("rst_wen", {31'd0, obs_wen}, 32'd0);
        idle();
        chk("idle_ready", {31'd0, obs_ready}, 32'd1);
        chk("idle_pend", obs_pend, 32'd0);

        // LR only
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("lr_c0_wen", {31'd0, obs_wen}, 32'd0);
        idle();
        chk("lr_c1_idx", {27'd0, obs_idx}, 32'd5);
        chk("lr_c1_data", obs_data, 32'hDEADBEEF);
        chk("lr_c1_pend", obs_pend, 32'h20);
        idle();
        chk("lr_c2_pend", obs_pend, 32'd0);

        // Starvation
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 5'd3, 32'h33 + c, 1'b0, 5'd0, 32'd0);
            chk("starve_w_idx", {27'd0, obs_idx}, 32'd3);
        end
        step(1'b0, 1'b1, 5'd3, 32'h40, 1'b0, 5'd0, 32'd0);
        chk("starve_forced_idx", {27'd0, obs_idx}, 32'd7);
        chk("starve_forced_stall", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 1'b1, 5'd3, 32'h40, 1'b0, 5'd0, 32'd0);
        chk("starve_after_idx", {27'd0, obs_idx}, 32'd3);
        chk("starve_after_data", obs_data, 32'h40);

        // WAW
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd1);
        step(1'b0, 1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 32'd0);
        chk("waw_a_data", obs_data, 32'd1);
        chk("waw_a_stall", {31'd0, obs_stall}, 32'd1);
        step(1'b0, 1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 32'd0);
        chk("waw_b_data", obs_data, 32'd2);
        idle();
        chk("waw_final", drf[9], 32'd2);

        // Full FIFO with W writing x1 continuously
        lr_log.delete();
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0);
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hB0);
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC0);
        chk("full_ready", {31'd0, obs_ready}, 32'd0);
        acc = obs_ready;
        for (int k = 0; k < 20 && !acc; k++) begin
            step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC0);
            acc = obs_ready;
        end
        chk("full_c_accepted", {31'd0, acc}, 32'd1);
        for (int k = 0; k < 30 && q.size() > 0; k++) begin
            step(1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0);
        end
        idle();
        chk("full_log_len", lr_log.size(), 32'd3);
        if (lr_log.size() == 3) begin
            chk("full_order0", {27'd0, lr_log[0]}, 32'd10);
            chk("full_order1", {27'd0, lr_log[1]}, 32'd11);
            chk("full_order2", {27'd0, lr_log[2]}, 32'd12);
        end
        chk("full_drf12", drf[12], 32'hC0);

        // Reset mid-op and x0
        drf[4] = 32'd0;
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle();
        chk("rstmid_wen", {31'd0, obs_wen}, 32'd0);
        chk("rstmid_pend", obs_pend, 32'd0);
        idle();
        chk("rstmid_x4", drf[4], 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
        chk("x0_ready", {31'd0, obs_ready}, 32'd1);
        step(1'b0, 1'b1, 5'd0, 32'h98, 1'b0, 5'd0, 32'd0);
        chk("x0_wen", {31'd0, obs_wen}, 32'd0);
        chk("x0_stall", {31'd0, obs_stall}, 32'd0);

        // Random traffic; W holds its request while stalled
        wv_r = 1'b0; wi_r = 5'd0; wd_r = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!m_stall) begin
                wv_r = 1'($urandom_range(0, 1));
                wi_r = 5'($urandom_range(0, 15));
                wd_r = $urandom;
            end
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, wv_r, wi_r, wd_r,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
        end
        for (int k = 0; k < 10; k++) idle();
        for (int i = 1; i < 32; i++) chk("rf_final", drf[i], mrf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/letc_core_wb_arbiter.md
Name: letc_core_wb_arbiter

Overview:
- Owns the single integer register-file write port and shares it between two requesters:
  - the W stage (in-order, normally has priority);
  - long-latency (LR) results, e.g. the multicycle mul/div unit.
- Buffers LR results in a small FIFO and enforces ordering against W writes.
- Guarantees LR forward progress with a starvation counter.
- Exports a pending-rd bitmap so the hazard unit can interlock readers of not-yet-written registers.

Parameters:
- LR_FIFO_DEPTH, 2: LR result buffer entries; power of two, >=2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO head may lose arbitration before it is forced; >=1.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous, active-high reset.
- i_w_valid  in  1  W stage has an rd write this cycle.
- i_w_rd_idx  in  reg_idx_t  W destination register.
- i_w_rd_wdata  in  word_t  W write data.
- o_w_stall  out  1  W write not taken this cycle; W holds its inputs stable.
- i_lr_valid  in  1  LR unit presents a result.
- o_lr_ready  out  1  FIFO can accept.
- i_lr_rd_idx  in  reg_idx_t  LR destination register.
- i_lr_wdata  in  word_t  LR result.
- o_rd_idx  out  reg_idx_t  register-file write index.
- o_rd_wdata  out  word_t  register-file write data.
- o_rd_wen  out  1  register-file write enable.
- o_lr_pending  out  32  bit r set iff a FIFO entry targets xr.

Behaviour:
- **Clock and reset:** one clock (i_clk); reset i_rst is synchronous, active-high.
- **Reset:**
  - FIFO emptied, starve counter = 0.
  - While i_rst is high: o_lr_ready=0, o_rd_wen=0, o_w_stall=0, o_lr_pending=0, o_rd_idx=0, o_rd_wdata=0.
  - Reset mid-operation discards all buffered LR results.
- **x0 writes:**
  - W write with rd=0 is treated as granted (no stall, no wen).
  - LR handshake with rd=0 completes (ready honoured) but is not enqueued.
- **Enqueue:**
  - Occurs on i_lr_valid && o_lr_ready; o_lr_ready = !full && !i_rst.
  - Full FIFO deasserts ready even if a dequeue happens the same cycle; no ready-through-dequeue.
  - There is no bypass to the write port. LR accept to o_rd_wen takes a minimum of 1 cycle.
- **Request set:**
  - W candidate: i_w_valid && i_w_rd_idx!=0.
  - H candidate: FIFO non-empty (the head entry).
- **Arbitration** (combinational, evaluated in order, first match wins):
  1. W candidate and i_w_rd_idx matches any pending entry: grant H, stall W (WAW order; the LR result is older).
  2. W and H both candidates and starve_cnt==STARVE_LIMIT: grant H, stall W.
  3. W candidate: grant W.
  4. H candidate: grant H.
  5. Otherwise: no grant.
- **Write port outputs:**
  - Combinational from the grant; o_rd_wen=1 for any grant.
  - Only one write occurs per cycle.
- **Stall:** o_w_stall=1 only when W is a candidate and not granted.
- **Dequeue:** occurs on an H grant; the head pointer advances at the clock edge.
- **Starve counter:**
  - Saturating at STARVE_LIMIT.
  - Clears when H is granted or the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and H is not granted.
- **o_lr_pending:**
  - OR of one-hot(idx) over valid entries; computed combinationally from registered FIFO state.
  - Duplicate idx entries are allowed; the bit stays set until the last matching entry drains.
- **Pointers:** log2(DEPTH)+1 bits with wrap bit; full = MSBs differ and the rest are equal.

Decomposition:
- letc_core_pkg additions:
  - wb_req_s {reg_idx_t rd_idx; word_t wdata};
  - WB_LR_FIFO_DEPTH and WB_STARVE_LIMIT defaults.
- Sub-module letc_core_wb_lr_fifo:
  - parameterised depth of wb_req_s entries;
  - exposes head, full, empty, and the per-entry valid/idx vectors used to build o_lr_pending and the match check.
- The top level holds the arbiter, starve counter and x0 filtering.

Test Plan:
- **Reset then idle:** o_lr_ready=1, o_rd_wen=0, o_lr_pending=0.
- **LR only:** LR push x5=0xDEADBEEF at cycle 0 -> cycle 1 o_rd_wen=1, idx=5, wdata=0xDEADBEEF; o_lr_pending[5]=1 during cycle 1 only.
- **Starvation (STARVE_LIMIT=4):**
  - Stimulus: FIFO holds x7, W writes x3 every cycle.
  - W granted for 4 cycles.
  - 5th cycle: o_rd_idx=7 and o_w_stall=1.
  - Next cycle: W x3 is written.
- **WAW:** FIFO holds x9=1 and W writes x9=2 -> cycle A writes x9=1 with W stalled; cycle A+1 writes x9=2; the final register value is 2.
- **Full:**
  - Push 2 entries with W continuously writing x1 -> o_lr_ready=0.
  - Third LR valid is held until the forced drain frees an entry.
  - No loss or duplication: results appear in order.
- **Reset mid-op and x0:**
  - Push x4 and assert i_rst for 1 cycle -> FIFO empty, x4 never written.
  - LR push x0 -> handshake completes, o_rd_wen stays 0.
